// File: rtl/mux_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_arbiter_if
// Purpose  : Bundles the two source streams, the downstream output stage and
//            the mux select/busy status of the 2:1 stream arbiter.
// Modports : master - arbiter view (sources and iReady in; oReady*, oSel,
//                     oValid, oData, oLast, oBusy out)
//            slave  - environment view (drives sources and iReady)
// Signals  : iValid0/1, iData0/1, iLast0/1   source beats
//            oReady0/1                      per-source accept strobes
//            oSel                           mux select (1 = source 1)
//            oValid, oData, oLast, iReady   output register handshake
//            oBusy                          a grant is held
// Revision : 1.0  initial release
// ============================================================================
interface mux_arbiter_if #(
  parameter int pStreamBits = 32
);

  logic                   iValid0;
  logic                   iValid1;
  logic [pStreamBits-1:0] iData0;
  logic [pStreamBits-1:0] iData1;
  logic                   iLast0;
  logic                   iLast1;
  logic                   oReady0;
  logic                   oReady1;
  logic                   oSel;
  logic                   oValid;
  logic [pStreamBits-1:0] oData;
  logic                   oLast;
  logic                   iReady;
  logic                   oBusy;

  modport master (
    input  iValid0, iValid1, iData0, iData1, iLast0, iLast1, iReady,
    output oReady0, oReady1, oSel, oValid, oData, oLast, oBusy
  );

  modport slave (
    output iValid0, iValid1, iData0, iData1, iLast0, iLast1, iReady,
    input  oReady0, oReady1, oSel, oValid, oData, oLast, oBusy
  );

endinterface
`default_nettype wire

// File: rtl/mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_arbiter
// Purpose  : Two-requester round-robin arbiter/sequencer for the 2:1 stream
//            mux. Grants the shared path to one source for a whole packet,
//            drives the mux select and registers each forwarded beat into a
//            single output stage.
// Params   : pStreamBits - stream data width
//            pMaxBurst   - beats per grant cap (1..255), burst limit build only
// Ports    : clk - rising-edge clock
//            rst - asynchronous, active-low reset
//            bus - mux_arbiter_if.master (source streams, output stage,
//                  oSel, oBusy)
// Options  : MUX_ARB_BURST_LIMIT_EN - when defined, a grant also ends after
//            pMaxBurst accepted beats; the rest of the packet re-arbitrates.
// Revision : 1.0  initial release
// ============================================================================
module mux_arbiter #(
  parameter int pStreamBits = 32,
  parameter int pMaxBurst   = 16
) (
  input  wire logic    clk,
  input  wire logic    rst,
  mux_arbiter_if.master bus
);

  localparam int c_cnt_bits = $clog2(pMaxBurst + 1);

`ifdef MUX_ARB_BURST_LIMIT_EN
  localparam logic [c_cnt_bits-1:0] c_max_burst = c_cnt_bits'(pMaxBurst);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  state_t                  r_state;
  logic                    r_pri;     // preferred source on a tie in IDLE
  logic [c_cnt_bits-1:0]   r_cnt;     // beats accepted in the current grant
  logic                    r_sel;
  logic                    r_valid;
  logic [pStreamBits-1:0]  r_data;
  logic                    r_last;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  state_t                  w_state_next;
  logic                    w_slot_free;   // output stage can take a beat
  logic                    w_ready0;
  logic                    w_ready1;
  logic                    w_accept;
  logic                    w_owner;
  logic [pStreamBits-1:0]  w_src_data;
  logic                    w_src_last;
  logic                    w_grant_end;
  logic [c_cnt_bits-1:0]   w_cnt_inc;

  // The output stage frees up either when empty or when its beat drains this
  // cycle; this depends only on registered state and iReady, so no path from
  // iValid reaches oReady.
  assign w_slot_free = bus.iReady | ~r_valid;

  // Saturating increment: the counter must never wrap, even on packets longer
  // than its range in the build without the burst limit.
  assign w_cnt_inc = (&r_cnt) ? r_cnt : (r_cnt + 1'b1);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state, per-source ready, beat acceptance and grant end
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_ready0     = 1'b0;
    w_ready1     = 1'b0;
    w_accept     = 1'b0;
    w_owner      = 1'b0;
    w_src_data   = '0;
    w_src_last   = 1'b0;
    w_grant_end  = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (bus.iValid0 && bus.iValid1) begin
          w_state_next = r_pri ? OWN1 : OWN0;
        end else if (bus.iValid0) begin
          w_state_next = OWN0;
        end else if (bus.iValid1) begin
          w_state_next = OWN1;
        end
      end

      OWN0: begin
        w_ready0   = w_slot_free;
        w_accept   = bus.iValid0 & w_slot_free;
        w_owner    = 1'b0;
        w_src_data = bus.iData0;
        w_src_last = bus.iLast0;
      end

      OWN1: begin
        w_ready1   = w_slot_free;
        w_accept   = bus.iValid1 & w_slot_free;
        w_owner    = 1'b1;
        w_src_data = bus.iData1;
        w_src_last = bus.iLast1;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase

    // A grant is held while the owner idles mid-packet; it only ends on an
    // accepted beat.
    if (w_accept) begin
      if (w_src_last) begin
        w_grant_end = 1'b1;
      end
`ifdef MUX_ARB_BURST_LIMIT_EN
      if (w_cnt_inc == c_max_burst) begin
        w_grant_end = 1'b1;
      end
`endif
    end

    if (w_grant_end) begin
      w_state_next = IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // Priority pointer, beat counter and registered select
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pri <= 1'b0;
      r_cnt <= '0;
      r_sel <= 1'b0;
    end else begin
      // Select tracks the state register exactly: high only while in OWN1.
      r_sel <= (w_state_next == OWN1);
      if (w_grant_end) begin
        r_pri <= ~w_owner;
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output stage: single register, holds stable while stalled
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else begin
      if (w_accept) begin
        // Covers the simultaneous drain-and-refill case: valid stays high.
        r_valid <= 1'b1;
        r_data  <= w_src_data;
        r_last  <= w_src_last;
      end else if (bus.iReady) begin
        r_valid <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.oReady0 = w_ready0;
  assign bus.oReady1 = w_ready1;
  assign bus.oSel    = r_sel;
  assign bus.oValid  = r_valid;
  assign bus.oData   = r_data;
  assign bus.oLast   = r_last;
  assign bus.oBusy   = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_arbiter
// Purpose  : Directed self-checking bench for mux_arbiter. Source beats are
//            queued as {last, data}; the forwarded beat stream, its cycle
//            spacing and stall behaviour are compared with hand-computed
//            expectations.
// Options  : MUX_ARB_BURST_LIMIT_EN selects the burst-limited expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_mux_arbiter;

  localparam int c_bits = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mux_arbiter_if #(.pStreamBits(c_bits)) bus();

  mux_arbiter #(
    .pStreamBits (c_bits),
    .pMaxBurst   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_stall  = 0;
  int          stall_lo = -1;
  int          stall_hi = -1;
  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic [32:0] exp_q[$];
  int          exp_gap[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [32:0] beat(input logic last, input logic [31:0] d);
    return {last, d};
  endfunction

  function automatic logic [63:0] outs();
    return {26'd0, bus.oBusy, bus.oValid, bus.oSel, bus.oReady0, bus.oReady1,
            bus.oLast, bus.oData};
  endfunction

  function automatic logic rdy_at(input int k);
    return !(k >= stall_lo && k <= stall_hi);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_srcs();
    if (q0.size() > 0) begin
      bus.iValid0 = 1'b1; bus.iData0 = q0[0][31:0]; bus.iLast0 = q0[0][32];
    end else begin
      bus.iValid0 = 1'b0; bus.iData0 = '0; bus.iLast0 = 1'b0;
    end
    if (q1.size() > 0) begin
      bus.iValid1 = 1'b1; bus.iData1 = q1[0][31:0]; bus.iLast1 = q1[0][32];
    end else begin
      bus.iValid1 = 1'b0; bus.iData1 = '0; bus.iLast1 = 1'b0;
    end
  endtask

  // Sources are driven from q0/q1 while reset is held; release lands just
  // after a rising edge so the next edge is the first active one.
  task automatic do_reset(input string name);
    bus.iReady = 1'b1;
    drive_srcs();
    step();
    rst = 1'b0;
    step();
    step();
    check({name, "_rst"}, outs(), 64'd0);
    rst = 1'b1;
  endtask

  task automatic run(input string name, input int max_cyc);
    logic [32:0] cap[$];
    int          capcyc[$];
    logic        f0, f1, stalled_prev, done;
    logic [32:0] prev;
    int          k;
    k = 0; done = 1'b0; stalled_prev = 1'b0; prev = '0; n_stall = 0;
    drive_srcs();
    bus.iReady = rdy_at(0);
    while (!done && k < max_cyc) begin
      @(negedge clk);
      f0 = bus.iValid0 & bus.oReady0;
      f1 = bus.iValid1 & bus.oReady1;
      if (bus.oValid && bus.iReady) begin
        cap.push_back({bus.oLast, bus.oData});
        capcyc.push_back(k);
      end
      if (bus.oValid && !bus.iReady) begin
        n_stall++;
        check({name, "_stall_rdy"}, 64'({bus.oReady0, bus.oReady1}), 64'd0);
        if (stalled_prev) check({name, "_stall_hold"}, 64'({bus.oLast, bus.oData}), 64'(prev));
        stalled_prev = 1'b1;
        prev = {bus.oLast, bus.oData};
      end else begin
        stalled_prev = 1'b0;
      end
      step();
      k++;
      if (f0) void'(q0.pop_front());
      if (f1) void'(q1.pop_front());
      drive_srcs();
      bus.iReady = rdy_at(k);
      done = (q0.size() == 0) && (q1.size() == 0) && !bus.oValid;
    end
    check({name, "_done"}, 64'(done), 64'd1);
    check({name, "_len"}, 64'(cap.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < cap.size()) check({name, "_beat"}, 64'(cap[i]), 64'(exp_q[i]));
    end
    for (int i = 0; i < exp_gap.size(); i++) begin
      if (i + 1 < capcyc.size())
        check({name, "_gap"}, 64'(capcyc[i+1] - capcyc[i]), 64'(exp_gap[i]));
    end
    stall_lo = -1;
    stall_hi = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iValid0 = 1'b0; bus.iValid1 = 1'b0;
    bus.iData0  = '0;   bus.iData1  = '0;
    bus.iLast0  = 1'b0; bus.iLast1  = 1'b0;
    bus.iReady  = 1'b1;

    // Idle after reset: nothing asserted for 10 cycles.
    do_reset("t1");
    for (int i = 0; i < 10; i++) begin
      step();
      check("t1_idle", outs(), 64'd0);
    end

    // Source 1 alone, 3 beats, exact cycle-by-cycle latency.
    q0.delete(); q1.delete();
    do_reset("t2");
    bus.iValid1 = 1'b1; bus.iData1 = 32'hA1; bus.iLast1 = 1'b0;
    #1;
    check("t2_no_comb_rdy", 64'(bus.oReady1), 64'd0);
    step();
    check("t2_grant", 64'({bus.oSel, bus.oBusy, bus.oReady1, bus.oReady0, bus.oValid}), 64'h1C);
    step();
    check("t2_b1", 64'({bus.oValid, bus.oLast, bus.oData}), {30'd0, 2'b10, 32'hA1});
    bus.iData1 = 32'hA2;
    step();
    check("t2_b2", 64'({bus.oValid, bus.oLast, bus.oData}), {30'd0, 2'b10, 32'hA2});
    bus.iData1 = 32'hA3; bus.iLast1 = 1'b1;
    step();
    check("t2_b3", 64'({bus.oValid, bus.oLast, bus.oData}), {30'd0, 2'b11, 32'hA3});
    check("t2_release", 64'({bus.oSel, bus.oBusy}), 64'd0);
    bus.iValid1 = 1'b0; bus.iLast1 = 1'b0;
    step();
    check("t2_drain", 64'(bus.oValid), 64'd0);

    // Priority returned to source 0 after source 1's grant.
    q0 = '{beat(1'b1, 32'h60)};
    q1 = '{beat(1'b1, 32'h70)};
    exp_q = '{beat(1'b1, 32'h60), beat(1'b1, 32'h70)};
    exp_gap = '{2};
    run("t2_pri", 40);

    // Both sources busy from reset with 2-beat packets: alternating grants,
    // contiguous packets, one dead cycle between grants.
    q0 = '{beat(1'b0, 32'h10), beat(1'b1, 32'h11), beat(1'b0, 32'h12), beat(1'b1, 32'h13)};
    q1 = '{beat(1'b0, 32'h20), beat(1'b1, 32'h21), beat(1'b0, 32'h22), beat(1'b1, 32'h23)};
    do_reset("t3");
    exp_q = '{beat(1'b0, 32'h10), beat(1'b1, 32'h11), beat(1'b0, 32'h20), beat(1'b1, 32'h21),
              beat(1'b0, 32'h12), beat(1'b1, 32'h13), beat(1'b0, 32'h22), beat(1'b1, 32'h23)};
    exp_gap = '{1, 2, 1, 2, 1, 2, 1};
    run("t3", 80);

    // Downstream stall for three cycles mid-packet.
    q0 = '{beat(1'b0, 32'h31), beat(1'b0, 32'h32), beat(1'b0, 32'h33), beat(1'b1, 32'h34)};
    q1.delete();
    do_reset("t4");
    exp_q = '{beat(1'b0, 32'h31), beat(1'b0, 32'h32), beat(1'b0, 32'h33), beat(1'b1, 32'h34)};
    exp_gap.delete();
    stall_lo = 2;
    stall_hi = 4;
    run("t4", 60);
    check("t4_stall_cycles", 64'(n_stall), 64'd3);

    // 6-beat packet on source 0 with source 1 pending.
    q0 = '{beat(1'b0, 32'h40), beat(1'b0, 32'h41), beat(1'b0, 32'h42),
           beat(1'b0, 32'h43), beat(1'b0, 32'h44), beat(1'b1, 32'h45)};
    q1 = '{beat(1'b0, 32'h50), beat(1'b1, 32'h51)};
    do_reset("t5");
`ifdef MUX_ARB_BURST_LIMIT_EN
    exp_q = '{beat(1'b0, 32'h40), beat(1'b0, 32'h41), beat(1'b0, 32'h42), beat(1'b0, 32'h43),
              beat(1'b0, 32'h50), beat(1'b1, 32'h51), beat(1'b0, 32'h44), beat(1'b1, 32'h45)};
    exp_gap = '{1, 1, 1, 2, 1, 2, 1};
`else
    exp_q = '{beat(1'b0, 32'h40), beat(1'b0, 32'h41), beat(1'b0, 32'h42), beat(1'b0, 32'h43),
              beat(1'b0, 32'h44), beat(1'b1, 32'h45), beat(1'b0, 32'h50), beat(1'b1, 32'h51)};
    exp_gap = '{1, 1, 1, 1, 1, 2, 1};
`endif
    run("t5", 80);

    // Asynchronous reset mid-packet; pointer is 1 beforehand so the restart
    // order shows it was cleared.
    q0 = '{beat(1'b1, 32'h81)};
    q1.delete();
    do_reset("t6");
    exp_q = '{beat(1'b1, 32'h81)};
    exp_gap.delete();
    run("t6_pre", 40);
    bus.iReady = 1'b0;
    bus.iValid0 = 1'b1; bus.iData0 = 32'h82; bus.iLast0 = 1'b0;
    step();
    step();
    check("t6_inflight", 64'({bus.oValid, bus.oData}), {31'd0, 1'b1, 32'h82});
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_clear", outs(), 64'd0);
    bus.iValid0 = 1'b0; bus.iData0 = '0;
    step();
    step();
    rst = 1'b1;
    q0 = '{beat(1'b1, 32'h90)};
    q1 = '{beat(1'b1, 32'hA0)};
    exp_q = '{beat(1'b1, 32'h90), beat(1'b1, 32'hA0)};
    exp_gap = '{2};
    run("t6_restart", 40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
